// File: rtl/exe_divider.sv
// EXE-stage multi-cycle 32-bit divider (DIV/DIVU). Uses restoring division, producing one quotient bit per cycle.
// The quotient goes to LO and the remainder goes to HI.
module exe_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_DivStart,
    input  logic        EXE_DivSigned,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    input  logic        EXE_Flush,
    output logic        Div_Stall,
    output logic        Div_Done,
    output logic [31:0] Div_Quotient,
    output logic [31:0] Div_Remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    div_state_t  state_r;
    div_state_t  state_nxt_s;
    logic [31:0] dividend_r;
    logic [31:0] divisor_r;
    logic [31:0] rem_r;
    logic [31:0] quot_r;
    logic [4:0]  count_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        done_r;
    logic [31:0] quotient_r;
    logic [31:0] remainder_r;

    logic        start_s;
    logic [32:0] partial_s;
    logic [32:0] diff_s;
    logic        q_bit_s;
    logic [31:0] rem_nxt_s;
    logic [31:0] quot_nxt_s;

    // Two's-complement negate when requested; serves both magnitude extraction and sign fix-up.
    function automatic logic [31:0] cond_neg(input logic [31:0] val, input logic neg);
        if (neg) begin
            cond_neg = ~val + 32'd1;
        end else begin
            cond_neg = val;
        end
    endfunction

    assign start_s       = (state_r == IDLE) & EXE_DivStart & ~EXE_Flush;
    assign Div_Stall     = start_s | (state_r == CALC);
    assign Div_Done      = done_r;
    assign Div_Quotient  = quotient_r;
    assign Div_Remainder = remainder_r;

    // One restoring step: shift in the next dividend bit, then subtract if the divisor fits.
    always_comb begin
        partial_s  = {rem_r, dividend_r[31]};
        diff_s     = partial_s - {1'b0, divisor_r};
        q_bit_s    = (partial_s >= {1'b0, divisor_r});
        rem_nxt_s  = partial_s[31:0];
        quot_nxt_s = {quot_r[30:0], q_bit_s};
        if (q_bit_s) begin
            rem_nxt_s = diff_s[31:0];
        end else begin
            rem_nxt_s = partial_s[31:0];
        end
    end

    // Next-state logic; a flush returns to IDLE from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (EXE_Flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (EXE_DivStart) begin
                        state_nxt_s = CALC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CALC: begin
                    if (count_r == 5'd31) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, operand/iteration registers and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            dividend_r  <= 32'd0;
            divisor_r   <= 32'd0;
            rem_r       <= 32'd0;
            quot_r      <= 32'd0;
            count_r     <= 5'd0;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= 32'd0;
            remainder_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        dividend_r <= cond_neg(EXE_BusA, EXE_DivSigned & EXE_BusA[31]);
                        divisor_r  <= cond_neg(EXE_BusB, EXE_DivSigned & EXE_BusB[31]);
                        q_neg_r    <= EXE_DivSigned & (EXE_BusA[31] ^ EXE_BusB[31]);
                        r_neg_r    <= EXE_DivSigned & EXE_BusA[31];
                        rem_r      <= 32'd0;
                        quot_r     <= 32'd0;
                        count_r    <= 5'd0;
                    end else begin
                        count_r    <= count_r;
                    end
                end
                CALC: begin
                    dividend_r <= {dividend_r[30:0], 1'b0};
                    rem_r      <= rem_nxt_s;
                    quot_r     <= quot_nxt_s;
                    count_r    <= count_r + 5'd1;
                    // Final step feeds the sign-corrected result straight into the outputs.
                    if (state_nxt_s == DONE) begin
                        quotient_r  <= cond_neg(quot_nxt_s, q_neg_r);
                        remainder_r <= cond_neg(rem_nxt_s, r_neg_r);
                    end else begin
                        quotient_r  <= quotient_r;
                    end
                end
                DONE:    count_r <= count_r;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_divider.sv
// Directed, table-driven bench for exe_divider: result values, stall/done timing,
// and the flush, reset and back-to-back corner sequences.
module tb_exe_divider;

    logic        clk;
    logic        rst;
    logic        EXE_DivStart;
    logic        EXE_DivSigned;
    logic [31:0] EXE_BusA;
    logic [31:0] EXE_BusB;
    logic        EXE_Flush;
    logic        Div_Stall;
    logic        Div_Done;
    logic [31:0] Div_Quotient;
    logic [31:0] Div_Remainder;

    int n_cmp;
    int n_err;
    logic [31:0] last_q;
    logic [31:0] last_r;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        string       name;
    } vec_t;

    vec_t tbl[9];

    exe_divider dut (
        .clk           (clk),
        .rst           (rst),
        .EXE_DivStart  (EXE_DivStart),
        .EXE_DivSigned (EXE_DivSigned),
        .EXE_BusA      (EXE_BusA),
        .EXE_BusB      (EXE_BusB),
        .EXE_Flush     (EXE_Flush),
        .Div_Stall     (Div_Stall),
        .Div_Done      (Div_Done),
        .Div_Quotient  (Div_Quotient),
        .Div_Remainder (Div_Remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide at the current cycle N; checks stall over N..N+32, done only at N+33, and the results.
    // Returns just after the edge that ends the DONE cycle, with start still high.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [31:0] eq, input logic [31:0] er, input string name);
        int bad_c;
        bad_c         = -1;
        EXE_BusA      = a;
        EXE_BusB      = b;
        EXE_DivSigned = sgn;
        EXE_Flush     = 1'b0;
        EXE_DivStart  = 1'b1;
        for (int c = 0; c <= 33; c++) begin
            @(negedge clk);
            if (bad_c < 0 && (Div_Stall !== (c <= 32) || Div_Done !== (c == 33))) begin
                bad_c = c;
            end
            if (c == 33) begin
                check({name, " quotient"}, Div_Quotient, eq);
                check({name, " remainder"}, Div_Remainder, er);
            end
            step();
        end
        check({name, " timing (first bad cycle, -1 = none)"}, bad_c, -1);
        last_q = eq;
        last_r = er;
    endtask

    // One IDLE cycle with start low: no stall, no second done pulse, results held.
    task automatic idle_check(input string name);
        EXE_DivStart = 1'b0;
        EXE_Flush    = 1'b0;
        @(negedge clk);
        check({name, " idle stall"}, {31'd0, Div_Stall}, 32'd0);
        check({name, " idle done"}, {31'd0, Div_Done}, 32'd0);
        check({name, " hold quotient"}, Div_Quotient, last_q);
        step();
    endtask

    initial begin
        tbl[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          "divu 100/7"};
        tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  "div -7/2"};
        tbl[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          "div 7/-2"};
        tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          "div overflow"};
        tbl[4] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          "divu 5/0"};
        tbl[5] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          "divu max/1"};
        tbl[6] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'd1,          32'hFFFF_FFF9,  "div -7/0"};
        tbl[7] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          "divu big/2"};
        tbl[8] = '{32'd1000,       32'd1000,       1'b1, 32'd1,          32'd0,          "div 1000/1000"};

        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b0;
        EXE_DivStart  = 1'b0;
        EXE_DivSigned = 1'b0;
        EXE_BusA      = 32'd0;
        EXE_BusB      = 32'd0;
        EXE_Flush     = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("reset quotient", Div_Quotient, 32'd0);
        check("reset remainder", Div_Remainder, 32'd0);
        check("reset done", {31'd0, Div_Done}, 32'd0);
        check("reset stall", {31'd0, Div_Stall}, 32'd0);
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_div(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].q, tbl[i].r, tbl[i].name);
            idle_check(tbl[i].name);
        end

        // Flush and start in the same IDLE cycle: flush wins.
        EXE_BusA     = 32'd50;
        EXE_BusB     = 32'd5;
        EXE_DivStart = 1'b1;
        EXE_Flush    = 1'b1;
        @(negedge clk);
        check("flush+start stall", {31'd0, Div_Stall}, 32'd0);
        step();
        idle_check("flush+start");

        // Flush mid-operation: start 100/7 at cycle 0, flush at cycle 10.
        EXE_BusA      = 32'd100;
        EXE_BusB      = 32'd7;
        EXE_DivSigned = 1'b0;
        EXE_DivStart  = 1'b1;
        repeat (10) step();
        EXE_DivStart = 1'b0;
        EXE_Flush    = 1'b1;
        @(negedge clk);
        check("flush cycle stall", {31'd0, Div_Stall}, 32'd1);
        step();
        EXE_Flush = 1'b0;
        @(negedge clk);
        check("after flush stall", {31'd0, Div_Stall}, 32'd0);
        check("after flush done", {31'd0, Div_Done}, 32'd0);
        check("after flush quotient", Div_Quotient, last_q);
        check("after flush remainder", Div_Remainder, last_r);
        step();
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "divu 9/3 after flush");
        idle_check("divu 9/3");

        // Reset mid-operation, then a clean DIVU 10/3.
        EXE_BusA     = 32'd100;
        EXE_BusB     = 32'd7;
        EXE_DivStart = 1'b1;
        repeat (5) step();
        EXE_DivStart = 1'b0;
        rst          = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid reset quotient", Div_Quotient, 32'd0);
        check("mid reset remainder", Div_Remainder, 32'd0);
        check("mid reset done", {31'd0, Div_Done}, 32'd0);
        check("mid reset stall", {31'd0, Div_Stall}, 32'd0);
        step();
        run_div(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, "divu 10/3 after reset");
        idle_check("divu 10/3");

        // Back-to-back with start held high; the second done must land 34 cycles after the first.
        run_div(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, "b2b divu 20/6");
        run_div(32'd20, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFD, 32'd2, "b2b div 20/-6");
        idle_check("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
